// File: rtl/spec_pipe_buffer.sv
// Elastic inter-stage buffer with speculative-entry tagging.
// Circular store of DEPTH {data, spec} entries with valid/ready on both sides.
// Speculative entries are squashed on a branch miss, and their tags are
// cleared when the branch resolves. A flush drops everything.
module spec_pipe_buffer #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_spec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_spec,
    input  logic              branch_miss,
    input  logic              branch_resolved,
    input  logic              flush,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0]  mem_spec;
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     wptr;

    logic [PW-1:0]     rptr_n;
    logic [PW-1:0]     wptr_n;
    logic [CNT_W-1:0]  count_n;
    logic [DEPTH-1:0]  spec_n;
    logic              push;
    logic              pop;
    logic              found;
    logic [CNT_W-1:0]  koff;

    // Handshake and head presentation; head is read straight from storage so
    // there is no bypass from in_* to out_*.
    always_comb begin
        in_ready  = (count != CNT_W'(DEPTH)) && !branch_miss && !flush;
        out_data  = mem_data[rptr];
        out_spec  = mem_spec[rptr];
        out_valid = (count != '0) && !flush && !(branch_miss && mem_spec[rptr]);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Next-state: pointer/count updates, spec tag maintenance and squash.
    always_comb begin
        rptr_n  = rptr;
        wptr_n  = wptr;
        count_n = count;
        spec_n  = mem_spec;
        found   = 1'b0;
        koff    = '0;

        // Oldest speculative entry, as an offset from the head.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && (CNT_W'(i) < count) && mem_spec[rptr + PW'(i)]) begin
                found = 1'b1;
                koff  = CNT_W'(i);
            end
        end

        if (flush) begin
            rptr_n  = '0;
            wptr_n  = '0;
            count_n = '0;
        end else if (branch_miss) begin
            // Pushes are blocked here; a pop can only take a non-spec head.
            if (pop) begin
                rptr_n = rptr + PW'(1);
            end
            if (found) begin
                wptr_n  = rptr + PW'(koff);
                count_n = koff - CNT_W'(pop);
            end else begin
                count_n = count - CNT_W'(pop);
            end
        end else begin
            if (branch_resolved) begin
                spec_n = '0;
            end
            if (pop) begin
                rptr_n = rptr + PW'(1);
            end
            if (push) begin
                wptr_n       = wptr + PW'(1);
                spec_n[wptr] = in_spec && !branch_resolved;
            end
            count_n = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State register and payload storage.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            mem_spec <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
            end
        end else begin
            rptr     <= rptr_n;
            wptr     <= wptr_n;
            count    <= count_n;
            mem_spec <= spec_n;
            if (push) begin
                mem_data[wptr] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_spec_pipe_buffer.sv
// Self-checking bench for spec_pipe_buffer: directed vector table, async
// reset sequence, then randomized traffic against a queue reference model.
module tb_spec_pipe_buffer;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic              CLK;
    logic              nrst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_spec;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_spec;
    logic              branch_miss;
    logic              branch_resolved;
    logic              flush;
    logic [CNT_W-1:0]  count;

    spec_pipe_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK             (CLK),
        .nrst            (nrst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_spec         (in_spec),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_spec        (out_spec),
        .branch_miss     (branch_miss),
        .branch_resolved (branch_resolved),
        .flush           (flush),
        .count           (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic              iv;
        logic [DATA_W-1:0] d;
        logic              is;
        logic              ordy;
        logic              bm;
        logic              br;
        logic              fl;
        logic              e_ir;
        logic              e_ov;
        logic [DATA_W-1:0] e_od;
        logic              e_os;
        logic [CNT_W-1:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              spec;
    } ent_t;

    ent_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    vec_t tbl[39];

    function automatic vec_t mk(logic iv, logic [DATA_W-1:0] d, logic is, logic ordy,
                                logic bm, logic br, logic fl, logic e_ir, logic e_ov,
                                logic [DATA_W-1:0] e_od, logic e_os, logic [CNT_W-1:0] e_cnt);
        vec_t v;
        v.iv = iv; v.d = d; v.is = is; v.ordy = ordy; v.bm = bm; v.br = br; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_os = e_os; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // One clock: drive, compare against model (and table if asked), advance model.
    task automatic tick(input bit use_tbl, input vec_t v);
        logic e_ir, e_ov, psh, pp, has_spec;
        in_valid = v.iv; in_data = v.d; in_spec = v.is; out_ready = v.ordy;
        branch_miss = v.bm; branch_resolved = v.br; flush = v.fl;
        #2;
        e_ir = (q.size() < DEPTH) && !v.fl && !v.bm;
        e_ov = (q.size() > 0) && !v.fl && !(v.bm && q[0].spec);
        chk("in_ready", DATA_W'(in_ready), DATA_W'(e_ir));
        chk("out_valid", DATA_W'(out_valid), DATA_W'(e_ov));
        chk("count", DATA_W'(count), DATA_W'(q.size()));
        if (e_ov) begin
            chk("out_data", out_data, q[0].data);
            chk("out_spec", DATA_W'(out_spec), DATA_W'(q[0].spec));
        end
        if (use_tbl) begin
            chk("tbl_in_ready", DATA_W'(in_ready), DATA_W'(v.e_ir));
            chk("tbl_out_valid", DATA_W'(out_valid), DATA_W'(v.e_ov));
            chk("tbl_count", DATA_W'(count), DATA_W'(v.e_cnt));
            if (v.e_ov) begin
                chk("tbl_out_data", out_data, v.e_od);
                chk("tbl_out_spec", DATA_W'(out_spec), DATA_W'(v.e_os));
            end
        end
        psh = v.iv && e_ir;
        pp  = e_ov && v.ordy;
        has_spec = 1'b0;
        foreach (q[i]) if (q[i].spec) has_spec = 1'b1;
        assert (!(psh && !v.is && !v.br && has_spec))
            else $error("non-spec push behind speculative entries at cycle %0d", cyc);
        @(posedge CLK);
        if (v.fl) begin
            q.delete();
        end else if (v.bm) begin
            if (pp) void'(q.pop_front());
            while (q.size() > 0 && q[$].spec) void'(q.pop_back());
        end else begin
            if (pp) void'(q.pop_front());
            if (v.br) foreach (q[i]) q[i].spec = 1'b0;
            if (psh) q.push_back('{data: v.d, spec: v.is && !v.br});
        end
        cyc++;
        #1;
    endtask

    initial begin
        vec_t v;
        bit   spec_mode;

        //          iv  d      is ordy bm br fl   ir ov od     os cnt
        tbl[0]  = mk(0, 'h00, 0, 0,   0, 0, 0,   1, 0, 'h00, 0, 0);
        tbl[1]  = mk(1, 'h11, 0, 0,   0, 0, 0,   1, 0, 'h00, 0, 0);
        tbl[2]  = mk(0, 'h00, 0, 0,   0, 0, 0,   1, 1, 'h11, 0, 1);
        tbl[3]  = mk(0, 'h00, 0, 1,   0, 0, 0,   1, 1, 'h11, 0, 1);
        tbl[4]  = mk(1, 'h01, 0, 0,   0, 0, 0,   1, 0, 'h00, 0, 0);
        tbl[5]  = mk(1, 'h02, 0, 0,   0, 0, 0,   1, 1, 'h01, 0, 1);
        tbl[6]  = mk(1, 'h03, 0, 0,   0, 0, 0,   1, 1, 'h01, 0, 2);
        tbl[7]  = mk(1, 'h04, 0, 0,   0, 0, 0,   1, 1, 'h01, 0, 3);
        tbl[8]  = mk(1, 'h05, 0, 1,   0, 0, 0,   0, 1, 'h01, 0, 4);
        tbl[9]  = mk(1, 'h05, 0, 0,   0, 0, 0,   1, 1, 'h02, 0, 3);
        tbl[10] = mk(0, 'h00, 0, 1,   0, 0, 0,   0, 1, 'h02, 0, 4);
        tbl[11] = mk(0, 'h00, 0, 1,   0, 0, 0,   1, 1, 'h03, 0, 3);
        tbl[12] = mk(0, 'h00, 0, 1,   0, 0, 0,   1, 1, 'h04, 0, 2);
        tbl[13] = mk(0, 'h00, 0, 1,   0, 0, 0,   1, 1, 'h05, 0, 1);
        tbl[14] = mk(0, 'h00, 0, 0,   0, 0, 0,   1, 0, 'h00, 0, 0);
        tbl[15] = mk(1, 'h0A, 0, 0,   0, 0, 0,   1, 0, 'h00, 0, 0);
        tbl[16] = mk(1, 'h0B, 0, 0,   0, 0, 0,   1, 1, 'h0A, 0, 1);
        tbl[17] = mk(1, 'h0C, 1, 0,   0, 0, 0,   1, 1, 'h0A, 0, 2);
        tbl[18] = mk(1, 'h0D, 1, 0,   0, 0, 0,   1, 1, 'h0A, 0, 3);
        tbl[19] = mk(0, 'h00, 0, 1,   1, 0, 0,   0, 1, 'h0A, 0, 4);
        tbl[20] = mk(0, 'h00, 0, 0,   0, 0, 0,   1, 1, 'h0B, 0, 1);
        tbl[21] = mk(0, 'h00, 0, 1,   0, 0, 0,   1, 1, 'h0B, 0, 1);
        tbl[22] = mk(0, 'h00, 0, 0,   0, 0, 0,   1, 0, 'h00, 0, 0);
        tbl[23] = mk(1, 'h0C, 1, 0,   0, 0, 0,   1, 0, 'h00, 0, 0);
        tbl[24] = mk(1, 'h0D, 1, 0,   0, 0, 0,   1, 1, 'h0C, 1, 1);
        tbl[25] = mk(0, 'h00, 0, 1,   1, 1, 0,   0, 0, 'h00, 0, 2);
        tbl[26] = mk(0, 'h00, 0, 0,   0, 0, 0,   1, 0, 'h00, 0, 0);
        tbl[27] = mk(1, 'h0E, 1, 0,   0, 0, 0,   1, 0, 'h00, 0, 0);
        tbl[28] = mk(1, 'h0F, 1, 0,   0, 0, 0,   1, 1, 'h0E, 1, 1);
        tbl[29] = mk(1, 'h10, 1, 0,   0, 1, 0,   1, 1, 'h0E, 1, 2);
        tbl[30] = mk(0, 'h00, 0, 1,   0, 0, 0,   1, 1, 'h0E, 0, 3);
        tbl[31] = mk(0, 'h00, 0, 1,   0, 0, 0,   1, 1, 'h0F, 0, 2);
        tbl[32] = mk(0, 'h00, 0, 1,   0, 0, 0,   1, 1, 'h10, 0, 1);
        tbl[33] = mk(0, 'h00, 0, 0,   0, 0, 0,   1, 0, 'h00, 0, 0);
        tbl[34] = mk(1, 'h21, 0, 0,   0, 0, 0,   1, 0, 'h00, 0, 0);
        tbl[35] = mk(1, 'h22, 0, 0,   0, 0, 0,   1, 1, 'h21, 0, 1);
        tbl[36] = mk(1, 'h23, 0, 0,   0, 0, 0,   1, 1, 'h21, 0, 2);
        tbl[37] = mk(1, 'h24, 0, 1,   0, 0, 1,   0, 0, 'h00, 0, 3);
        tbl[38] = mk(0, 'h00, 0, 0,   0, 0, 0,   1, 0, 'h00, 0, 0);

        in_valid = 0; in_data = '0; in_spec = 0; out_ready = 0;
        branch_miss = 0; branch_resolved = 0; flush = 0;
        nrst = 1'b1;
        #1 nrst = 1'b0;
        #1;
        chk("reset_out_valid", DATA_W'(out_valid), '0);
        chk("reset_out_data", out_data, '0);
        chk("reset_out_spec", DATA_W'(out_spec), '0);
        chk("reset_in_ready", DATA_W'(in_ready), DATA_W'(1));
        chk("reset_count", DATA_W'(count), '0);
        @(posedge CLK);
        @(negedge CLK);
        nrst = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 39; i++) tick(1'b1, tbl[i]);

        // Refill, drain one, then pull reset between clock edges.
        tick(1'b0, mk(1, 'h31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick(1'b0, mk(1, 'h32, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick(1'b0, mk(0, 'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("pre_reset_count", DATA_W'(count), DATA_W'(1));
        in_valid = 0; out_ready = 1;
        #2 nrst = 1'b0;
        #1;
        chk("async_out_valid", DATA_W'(out_valid), '0);
        chk("async_count", DATA_W'(count), '0);
        chk("async_in_ready", DATA_W'(in_ready), DATA_W'(1));
        q.delete();
        @(posedge CLK);
        @(negedge CLK);
        nrst = 1'b1;
        @(posedge CLK);
        #1;

        // Randomized traffic; upstream keeps spec pushes contiguous at the tail.
        spec_mode = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            v = mk(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.iv   = ($urandom_range(0, 9) < 7);
            v.d    = {$urandom, $urandom};
            v.is   = spec_mode || ($urandom_range(0, 3) == 0);
            v.ordy = ($urandom_range(0, 9) < 6);
            v.bm   = ($urandom_range(0, 19) == 0);
            v.br   = ($urandom_range(0, 11) == 0);
            v.fl   = ($urandom_range(0, 39) == 0);
            if (v.fl || v.bm || v.br) begin
                tick(1'b0, v);
                spec_mode = 1'b0;
            end else begin
                if (v.iv && v.is && q.size() < DEPTH) spec_mode = 1'b1;
                tick(1'b0, v);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
